// File: rtl/vram_pkg.sv
// Shared types and defaults for the video RAM arbiter: slot states, bank codes, widths.
package vram_pkg;

    localparam int VRAM_AW = 13;
    localparam int VRAM_DW = 8;

    localparam logic [1:0] BANK_BLUE   = 2'd0;
    localparam logic [1:0] BANK_RED    = 2'd1;
    localparam logic [1:0] BANK_GREENX = 2'd2;
    localparam logic [1:0] BANK_GREEN  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_CPU  = 2'd2
    } slot_state_t;

endpackage

// File: rtl/vram_req_latch.sv
// Four-phase CPU request capture: one access per cpu_req high period, re-armed only after req drops.
module vram_req_latch (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_req,
    input  logic i_done,
    output logic o_pending,
    output logic o_accept
);

    logic r_pending;
    logic r_armed;
    logic w_accept;

    assign w_accept  = i_req && r_armed && !r_pending;
    assign o_pending = r_pending;
    assign o_accept  = w_accept;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_pending <= 1'b0;
            r_armed   <= 1'b1;
        end else if (i_done) begin
            // A held request must fall before it can be taken again.
            r_pending <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            if (w_accept)
                r_pending <= 1'b1;
            if (!i_req)
                r_armed <= 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Slot arbiter sharing one SRAM port between video fetch (odd slots while vact) and the CPU.
// Optional VRAM_BLANK_ONLY_EN restricts CPU slots to vact=0.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          vact,
    input  logic [1:0]    vbank,
    input  logic [AW-1:0] vaddr,
    output logic [DW-1:0] vq,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_bank,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_d,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_ack,
    output logic          cpu_wait,
    output logic [AW+1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);

    slot_state_t   r_state;
    logic          r_phase;
    logic [DW-1:0] r_vq;
    logic [DW-1:0] r_cpu_q;
    logic          r_cpu_ack;
    logic [AW+1:0] r_mem_a;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_d;
    logic          r_req_we;
    logic [AW+1:0] r_req_a;
    logic [DW-1:0] r_req_d;

    logic w_pending;
    logic w_accept;
    logic w_cpu_done;
    logic w_vid_slot;
    logic w_cpu_slot;

    assign w_cpu_done = ce && (r_state == S_CPU);
    assign w_vid_slot = vact && r_phase;

    // The completing CPU slot must not be granted again on its own ending edge.
`ifdef VRAM_BLANK_ONLY_EN
    assign w_cpu_slot = !vact && w_pending && !w_cpu_done;
`else
    assign w_cpu_slot = w_pending && !w_cpu_done;
`endif

    vram_req_latch u_req (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_req     (cpu_req),
        .i_done    (w_cpu_done),
        .o_pending (w_pending),
        .o_accept  (w_accept)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_phase   <= 1'b0;
            r_vq      <= '0;
            r_cpu_q   <= '0;
            r_cpu_ack <= 1'b0;
            r_mem_a   <= '0;
            r_mem_we  <= 1'b0;
            r_mem_d   <= '0;
            r_req_we  <= 1'b0;
            r_req_a   <= '0;
            r_req_d   <= '0;
        end else begin
            r_cpu_ack <= w_cpu_done;
            // Request fields are latched so a request dropped while pending still completes intact.
            if (w_accept) begin
                r_req_we <= cpu_we;
                r_req_a  <= {cpu_bank, cpu_addr};
                r_req_d  <= cpu_d;
            end
            if (ce) begin
                r_phase <= vact ? ~r_phase : 1'b0;
                if (r_state == S_VID)
                    r_vq <= mem_q;
                if (w_cpu_done && !r_mem_we)
                    r_cpu_q <= mem_q;
                if (w_vid_slot) begin
                    r_state  <= S_VID;
                    r_mem_a  <= {vbank, vaddr};
                    r_mem_we <= 1'b0;
                end else if (w_cpu_slot) begin
                    r_state  <= S_CPU;
                    r_mem_a  <= r_req_a;
                    r_mem_d  <= r_req_d;
                    r_mem_we <= r_req_we;
                end else begin
                    r_state  <= S_IDLE;
                    r_mem_we <= 1'b0;
                end
            end
        end
    end

    assign vq       = r_vq;
    assign cpu_q    = r_cpu_q;
    assign cpu_ack  = r_cpu_ack;
    assign cpu_wait = w_pending;
    assign mem_a    = r_mem_a;
    assign mem_we   = r_mem_we;
    assign mem_d    = r_mem_d;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter; define VRAM_BLANK_ONLY_EN to check the blank-only variant.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ce;
    logic        vact;
    logic [1:0]  vbank;
    logic [12:0] vaddr;
    logic [7:0]  vq;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_bank;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q;
    logic        cpu_ack;
    logic        cpu_wait;
    logic [14:0] mem_a;
    logic        mem_we;
    logic [7:0]  mem_d;
    logic [7:0]  mem_q;

    int checks   = 0;
    int failures = 0;
    int extra;

    always #5 clock = ~clock;

    vram_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .vact     (vact),
        .vbank    (vbank),
        .vaddr    (vaddr),
        .vq       (vq),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_bank (cpu_bank),
        .cpu_addr (cpu_addr),
        .cpu_d    (cpu_d),
        .cpu_q    (cpu_q),
        .cpu_ack  (cpu_ack),
        .cpu_wait (cpu_wait),
        .mem_a    (mem_a),
        .mem_we   (mem_we),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    task automatic ce_edge();
        ce = 1'b1;
        @(posedge clock);
        #1;
        ce = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ce = 1'b0; vact = 1'b0; vbank = '0; vaddr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_bank = '0; cpu_addr = '0; cpu_d = '0; mem_q = '0;

        // Reset
        clk1(); clk1();
        chk("rst_vq", vq, 0);
        chk("rst_cpu_q", cpu_q, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_wait", cpu_wait, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_d", mem_d, 0);
        chk("rst_state", dut.r_state, S_IDLE);
        chk("rst_phase", dut.r_phase, 0);
        reset = 1'b1;

        // Video only: bank greenx, addr 0x0123 -> {2'b10, 13'h0123} = 15'h4123
        vact = 1'b1; vbank = BANK_GREENX; vaddr = 13'h0123; mem_q = 8'hA5;
        ce_edge(); clk1();
        chk("vid_first_idle", dut.r_state, S_IDLE);
        ce_edge();
        chk("vid_mem_a", mem_a, 15'h4123);
        chk("vid_state", dut.r_state, S_VID);
        chk("vid_vq_not_yet", vq, 0);
        clk1();
        ce_edge();
        chk("vid_vq_a5", vq, 8'hA5);
        clk1();
        mem_q = 8'h5A;
        ce_edge(); clk1();
        chk("vid_vq_held", vq, 8'hA5);
        ce_edge();
        chk("vid_vq_5a", vq, 8'h5A);
        clk1();

        // vact falls during a video slot: slot completes, phase forced 0
        ce_edge();
        chk("vfall_start", dut.r_state, S_VID);
        vact = 1'b0; mem_q = 8'h3E;
        clk1();
        ce_edge();
        chk("vfall_vq", vq, 8'h3E);
        chk("vfall_phase", dut.r_phase, 0);
        chk("vfall_state", dut.r_state, S_IDLE);
        clk1();

        // CPU write in blanking: bank red, addr 0x0010 -> 15'h2010
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_bank = BANK_RED; cpu_addr = 13'h0010; cpu_d = 8'h3C;
        clk1();
        chk("wr_wait", cpu_wait, 1);
        chk("wr_we_before", mem_we, 0);
        ce_edge();
        chk("wr_mem_a", mem_a, 15'h2010);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_d", mem_d, 8'h3C);
        chk("wr_no_ack_yet", cpu_ack, 0);
        clk1();
        chk("wr_we_held", mem_we, 1);
        ce_edge();
        chk("wr_ack", cpu_ack, 1);
        chk("wr_wait_drop", cpu_wait, 0);
        chk("wr_we_end", mem_we, 0);
        clk1();
        chk("wr_ack_pulse", cpu_ack, 0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            ce_edge();
            if (mem_we || cpu_ack || cpu_wait) extra++;
            clk1();
            if (mem_we || cpu_ack || cpu_wait) extra++;
        end
        chk("wr_held_no_repeat", extra, 0);
        cpu_req = 1'b0;
        clk1();

        // Contention: CPU read of green/0x1FFF raised on a phase=1 ce
        vact = 1'b1; vbank = BANK_BLUE; vaddr = 13'h0055;
        ce_edge(); clk1();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = BANK_GREEN; cpu_addr = 13'h1FFF;
        ce_edge();
        chk("ct_vid_first", mem_a, 15'h0055);
        chk("ct_wait", cpu_wait, 1);
        clk1();
        mem_q = 8'h77;
        ce_edge();
        chk("ct_vq", vq, 8'h77);
`ifdef VRAM_BLANK_ONLY_EN
        chk("bo_no_cpu_in_vact", dut.r_state, S_IDLE);
        chk("bo_wait_held", cpu_wait, 1);
        vact = 1'b0;
        clk1();
        ce_edge();
`endif
        chk("ct_cpu_mem_a", mem_a, 15'h7FFF);
        chk("ct_cpu_we", mem_we, 0);
        clk1();
        mem_q = 8'hC3;
        ce_edge();
        chk("ct_ack", cpu_ack, 1);
        chk("ct_cpu_q", cpu_q, 8'hC3);
        chk("ct_wait_drop", cpu_wait, 0);
        clk1();
        cpu_req = 1'b0; vact = 1'b0;
        clk1();

        // cpu_req dropped while pending: access completes with the latched fields
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = BANK_GREENX; cpu_addr = 13'h0ABC;
        clk1();
        cpu_req = 1'b0; cpu_addr = 13'h0000; cpu_bank = BANK_BLUE;
        ce_edge();
        chk("drop_mem_a", mem_a, 15'h4ABC);
        clk1();
        mem_q = 8'h6D;
        ce_edge();
        chk("drop_ack", cpu_ack, 1);
        chk("drop_cpu_q", cpu_q, 8'h6D);
        clk1();

        // Reset during a CPU write aborts it
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_bank = BANK_BLUE; cpu_addr = 13'h0005; cpu_d = 8'h99;
        clk1();
        ce_edge();
        chk("rmw_we_on", mem_we, 1);
        reset = 1'b0; cpu_req = 1'b0;
        clk1();
        chk("rmw_we_off", mem_we, 0);
        chk("rmw_no_ack", cpu_ack, 0);
        chk("rmw_wait", cpu_wait, 0);
        chk("rmw_vq", vq, 0);
        chk("rmw_mem_a", mem_a, 0);
        reset = 1'b1;
        ce_edge(); clk1();
        chk("rmw_no_replay", mem_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
